// File: rtl/mem_burst_reader_if.sv
// Bundles the request, memory-read and output-stream signals of the burst reader.
// The reader takes the master view; the environment driving it takes the slave view.
interface mem_burst_reader_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              REQ_VALID;
  logic              REQ_READY;
  logic [ADDR_W-1:0] REQ_ADDR;
  logic [ADDR_W-1:0] REQ_LEN;
  logic              MEM_RE;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [DATA_W-1:0] MEM_RDATA;
  logic              OUT_VALID;
  logic              OUT_READY;
  logic [DATA_W-1:0] OUT_DATA;
  logic              OUT_LAST;
  logic              BUSY;

  modport master (
    input  REQ_VALID, REQ_ADDR, REQ_LEN, MEM_RDATA, OUT_READY,
    output REQ_READY, MEM_RE, MEM_ADDR, OUT_VALID, OUT_DATA, OUT_LAST, BUSY
  );

  modport slave (
    output REQ_VALID, REQ_ADDR, REQ_LEN, MEM_RDATA, OUT_READY,
    input  REQ_READY, MEM_RE, MEM_ADDR, OUT_VALID, OUT_DATA, OUT_LAST, BUSY
  );
endinterface

// File: rtl/mem_burst_reader.sv
// Streams a burst of words out of a 1-cycle-latency synchronous memory onto a
// VALID/READY stream, using a 2-entry FIFO and read credits so no data is dropped.
module mem_burst_reader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic                CLK,
  input  logic                RST,
  mem_burst_reader_if.master  bus
);
  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [CNT_W-1:0]  issue_left_q, issue_left_d;
  logic [CNT_W-1:0]  out_left_q, out_left_d;
  logic              inflight_q, inflight_d;
  logic [1:0]        count_q, count_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] fifo_q [2];

  logic              out_valid, pop, push, mem_re, req_ready, last_word;
  logic [2:0]        credit;
  logic [CNT_W-1:0]  req_words;

  assign out_valid = (count_q != 2'd0) && !RST;
  assign pop       = out_valid && bus.OUT_READY;
  assign push      = inflight_q;
  assign last_word = (out_left_q == CNT_W'(1));
  assign req_words = {1'b0, bus.REQ_LEN} + CNT_W'(1);
  // Words held or already on their way; a slot being popped this cycle is reusable.
  assign credit    = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    mem_addr_d   = mem_addr_q;
    issue_left_d = issue_left_q;
    out_left_d   = pop ? out_left_q - CNT_W'(1) : out_left_q;
    inflight_d   = 1'b0;
    count_d      = count_q + {1'b0, push} - {1'b0, pop};
    wr_ptr_d     = push ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d     = pop ? ~rd_ptr_q : rd_ptr_q;
    req_ready    = 1'b0;
    mem_re       = 1'b0;

    unique case (state_q)
      IDLE: begin
        req_ready = !RST;
        if (bus.REQ_VALID && !RST) begin
          addr_d       = bus.REQ_ADDR;
          issue_left_d = req_words;
          out_left_d   = req_words;
          state_d      = READ;
        end
      end
      READ: begin
        mem_re = !RST && (credit < 3'd2);
        if (mem_re) begin
          mem_addr_d   = addr_q;
          addr_d       = addr_q + ADDR_W'(1);
          issue_left_d = issue_left_q - CNT_W'(1);
          inflight_d   = 1'b1;
          if (issue_left_q == CNT_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && last_word) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      mem_addr_q   <= '0;
      issue_left_q <= '0;
      out_left_q   <= '0;
      inflight_q   <= 1'b0;
      count_q      <= 2'd0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
    end else begin
      assert (!(push && !pop && count_q == 2'd2))
        else $error("mem_burst_reader: output fifo overflow");
      state_q      <= state_d;
      addr_q       <= addr_d;
      mem_addr_q   <= mem_addr_d;
      issue_left_q <= issue_left_d;
      out_left_q   <= out_left_d;
      inflight_q   <= inflight_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  // NOTE: FIFO storage is not reset; the count and the output gating hide stale entries.
  always_ff @(posedge CLK) begin
    if (push && !RST) fifo_q[wr_ptr_q] <= bus.MEM_RDATA;
  end

  assign bus.REQ_READY = req_ready;
  assign bus.MEM_RE    = mem_re;
  assign bus.MEM_ADDR  = RST ? '0 : (mem_re ? addr_q : mem_addr_q);
  assign bus.OUT_VALID = out_valid;
  assign bus.OUT_DATA  = out_valid ? fifo_q[rd_ptr_q] : '0;
  assign bus.OUT_LAST  = out_valid && last_word;
  assign bus.BUSY      = (state_q != IDLE) && !RST;
endmodule

// File: doc/mem_burst_reader.md
Name: mem_burst_reader

Overview:
- Read-side counterpart to the DFF-based storage array: takes a burst request (start address, word count) and streams the addressed words out.
- Drives read requests into a synchronous memory with 1-cycle read latency.
- Returns the data on a VALID/READY stream with a LAST marker.
- A 2-entry output FIFO absorbs backpressure, so no read data is ever dropped.

Parameters:
ADDR_W, 4, memory address width; depth = 2^ADDR_W words
DATA_W, 8, memory word width

Ports:
CLK  input  1  rising-edge clock, single clock domain
RST  input  1  synchronous reset, active-high
REQ_VALID  input  1  burst request present
REQ_READY  output  1  reader idle, can accept a request
REQ_ADDR  input  ADDR_W  start address of burst
REQ_LEN  input  ADDR_W  burst length minus one (0 = 1 word, 2^ADDR_W-1 = full memory)
MEM_RE  output  1  memory read enable
MEM_ADDR  output  ADDR_W  memory read address
MEM_RDATA  input  DATA_W  memory data, valid the cycle after MEM_RE
OUT_VALID  output  1  OUT_DATA holds a word
OUT_READY  input  1  consumer accepts word
OUT_DATA  output  DATA_W  read word
OUT_LAST  output  1  final word of burst
BUSY  output  1  burst in progress (state != IDLE)

Behaviour:
- Interface: one clock (CLK); reset RST is synchronous and active-high. All state updates on rising CLK.
- Reset: applied at the first CLK edge with RST=1.
  - State goes to IDLE; FIFO count, in-flight flag and counters go to 0.
  - Outputs while RST=1 and after: OUT_VALID=0, OUT_DATA=0, OUT_LAST=0, MEM_RE=0, MEM_ADDR=0, BUSY=0.
  - REQ_READY=0 while RST=1; REQ_READY=1 in the first cycle after RST falls.
- Reset mid-burst: aborts immediately.
  - In-flight memory data returning the next cycle is discarded.
  - FIFO contents are discarded.
- States:
  - IDLE: REQ_READY=1. On REQ_VALID&REQ_READY, latch addr=REQ_ADDR, issue_left=REQ_LEN+1 (ADDR_W+1 bits), out_left=REQ_LEN+1, then go to READ.
  - READ: issue reads. After the last read is issued, go to DRAIN.
  - DRAIN: no reads. On the handshake of the word with OUT_LAST=1, go to IDLE.
  - A new request is never accepted in the same cycle as the final pop; REQ_READY rises the next cycle.
- Request handling: REQ_VALID is ignored outside IDLE. A request held high during a burst is accepted only after return to IDLE.
- Read issue, combinational, in READ only:
  - MEM_RE = 1 when (count + inflight − pop) < 2, where pop = OUT_VALID & OUT_READY. The combinational path from OUT_READY to MEM_RE is intentional.
  - MEM_ADDR = addr when MEM_RE=1, else holds its last value.
  - On each issue: addr increments modulo 2^ADDR_W (15 → 0 wraps), issue_left decrements, inflight is set for the next cycle.
- Data capture: in the cycle after MEM_RE, MEM_RDATA is written into the FIFO at the clock edge.
  - Credit rule guarantees the FIFO never overflows; an overflow is a design error (assert in sim).
- Output:
  - OUT_VALID = (count != 0); OUT_DATA = FIFO head.
  - OUT_LAST = 1 when the head word is the final word of the burst (out_left==1).
  - While OUT_VALID=1 and OUT_READY=0, OUT_DATA and OUT_LAST stay stable.
  - Simultaneous push and pop keeps count unchanged.
- Latency: request handshake in cycle 0 → first MEM_RE in cycle 1 → first OUT_VALID in cycle 3.
- Throughput: with OUT_READY held at 1, one word per cycle.
- BUSY = 1 in READ and DRAIN.

Test Plan:
- mem[i]=i*16. After reset, request ADDR=3, LEN=3, OUT_READY=1 (handshake cycle 0):
  - MEM_RE in cycles 1–4 with addresses 3,4,5,6.
  - OUT_DATA 0x30,0x40,0x50,0x60 in cycles 3–6; OUT_LAST only with 0x60.
  - BUSY falls and REQ_READY rises in cycle 7.
- Wrap: ADDR=14, LEN=3 → MEM_ADDR 14,15,0,1; OUT_DATA 0xE0,0xF0,0x00,0x10.
- Backpressure: ADDR=0, LEN=7, OUT_READY=0 for 6 cycles after the first OUT_VALID, then 1:
  - MEM_RE stops once count+inflight=2.
  - OUT_DATA holds 0x00 while stalled.
  - All 8 words arrive in order, none lost or duplicated.
- Single word: ADDR=9, LEN=0 → one MEM_RE (addr 9), one OUT_VALID with OUT_DATA=0x90 and OUT_LAST=1.
- Reset mid-burst: RST=1 for 1 cycle in the cycle the 2nd word is presented:
  - Next cycle OUT_VALID=0, MEM_RE=0, BUSY=0.
  - A new request ADDR=5, LEN=1 returns exactly 0x50, 0x60 with no stale words.
- REQ_VALID held high across a full LEN=2 burst → exactly one acceptance during the burst; the second request is accepted the cycle after the final handshake.
